// File: rtl/dds_bank_pkg.sv
// Shared register-map offsets and CTRL/STATUS bit positions for the DDS
// increment bank. Offsets depend on the channel count, so they are helpers.
package dds_bank_pkg;

  // CTRL register bits (write-only, reads as 0)
  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_ABORT_BIT  = 1;

  // STATUS register bits
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_RAMPING_BIT = 1;

  // SHADOW[i] lives at i; the remaining blocks follow the two per-channel banks
  function automatic int unsigned OFS_ACTIVE(input int unsigned num_ch);
    return num_ch;
  endfunction

  function automatic int unsigned OFS_CTRL(input int unsigned num_ch);
    return 2 * num_ch;
  endfunction

  function automatic int unsigned OFS_STATUS(input int unsigned num_ch);
    return 2 * num_ch + 1;
  endfunction

  function automatic int unsigned OFS_STEP(input int unsigned num_ch);
    return 2 * num_ch + 2;
  endfunction

endpackage

// File: rtl/dds_slew_ch.sv
// One tuning-word channel: holds the committed target and the word currently
// driven to the phase accumulator, and walks the latter toward the former.
module dds_slew_ch
  import dds_bank_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              apply,    // commit being applied this cycle
  input  logic              abort,    // snap active onto target
  input  logic              tick,     // sample tick
  input  logic [DATA_W-1:0] shadow,
  input  logic [DATA_W-1:0] step,
  output logic [DATA_W-1:0] active,
  output logic              differs
);

  logic [DATA_W-1:0] target_reg, target_next;
  logic [DATA_W-1:0] active_reg, active_next;
  logic [DATA_W:0]   diff;
  logic              going_up;

  // Next target/active: commit load, abort snap, or one slew step per tick
  always_comb begin
    going_up    = (target_reg >= active_reg);
    diff        = going_up ? ({1'b0, target_reg} - {1'b0, active_reg})
                           : ({1'b0, active_reg} - {1'b0, target_reg});
    target_next = target_reg;
    active_next = active_reg;
    if (apply) begin
      target_next = shadow;
      // a zero step means the new word takes effect immediately
      if (step == '0) begin
        active_next = shadow;
      end else if (abort) begin
        active_next = target_reg;
      end
    end else if (abort) begin
      active_next = target_reg;
    end else if (tick) begin
      // the wide difference keeps the compare exact, so no overshoot or wrap
      if (diff <= {1'b0, step}) begin
        active_next = target_reg;
      end else if (going_up) begin
        active_next = active_reg + step;
      end else begin
        active_next = active_reg - step;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_reg <= '0;
      active_reg <= '0;
    end else begin
      target_reg <= target_next;
      active_reg <= active_next;
    end
  end

  assign active  = active_reg;
  assign differs = (active_reg != target_reg);

endmodule

// File: rtl/dds_increment_bank.sv
// Avalon-MM bank of DDS tuning words: shadow registers, a single pending
// commit applied on the sample tick, and optional slewing toward new targets.
module dds_increment_bank
  import dds_bank_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic                     sample_tick,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     update_pulse,
  output logic                     ramping
);

  localparam int unsigned ACTIVE_BASE = OFS_ACTIVE(NUM_CH);
  localparam int unsigned CTRL_ADDR   = OFS_CTRL(NUM_CH);
  localparam int unsigned STATUS_ADDR = OFS_STATUS(NUM_CH);
  localparam int unsigned STEP_ADDR   = OFS_STEP(NUM_CH);

  logic              wr;
  int unsigned       addr_idx;
  logic              ctrl_wr, commit_req, abort_req, apply;
  logic [DATA_W-1:0] shadow_reg [NUM_CH];
  logic [DATA_W-1:0] active_w   [NUM_CH];
  logic [NUM_CH-1:0] differs;
  logic [DATA_W-1:0] step_reg;
  logic              pending_reg, update_pulse_reg;

  assign wr         = chipselect & ~write_n;
  assign addr_idx   = 32'(address);
  assign ctrl_wr    = wr && (addr_idx == CTRL_ADDR);
  assign commit_req = ctrl_wr && writedata[CTRL_COMMIT_BIT];
  assign abort_req  = ctrl_wr && writedata[CTRL_ABORT_BIT];
  // pending is registered, so a commit written in a tick cycle waits for the next tick
  assign apply      = sample_tick && pending_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Shadow word for this channel; the applying tick sees the pre-write value
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          shadow_reg[gi] <= '0;
        end else if (wr && (addr_idx == gi)) begin
          shadow_reg[gi] <= writedata[DATA_W-1:0];
        end
      end

      dds_slew_ch #(.DATA_W(DATA_W)) u_ch (
        .clk     (clk),
        .reset   (reset),
        .apply   (apply),
        .abort   (abort_req),
        .tick    (sample_tick),
        .shadow  (shadow_reg[gi]),
        .step    (step_reg),
        .active  (active_w[gi]),
        .differs (differs[gi])
      );

      assign out_port[gi*DATA_W +: DATA_W] = active_w[gi];
    end
  endgenerate

  // STEP, single pending commit flag and the post-commit pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_reg         <= '0;
      pending_reg      <= 1'b0;
      update_pulse_reg <= 1'b0;
    end else begin
      if (wr && (addr_idx == STEP_ADDR)) begin
        step_reg <= writedata[DATA_W-1:0];
      end
      if (apply) begin
        pending_reg <= 1'b0;
      end else if (commit_req) begin
        pending_reg <= 1'b1;
      end
      update_pulse_reg <= apply;
    end
  end

  assign update_pulse = update_pulse_reg;
  assign ramping      = |differs;

  // Zero-latency read mux; unmapped and write-only addresses read 0
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_idx == 32'(i)) begin
        readdata = 32'(shadow_reg[i]);
      end
      if (addr_idx == ACTIVE_BASE + 32'(i)) begin
        readdata = 32'(active_w[i]);
      end
    end
    if (addr_idx == STATUS_ADDR) begin
      readdata[STATUS_RAMPING_BIT] = ramping;
      readdata[STATUS_PENDING_BIT] = pending_reg;
    end
    if (addr_idx == STEP_ADDR) begin
      readdata = 32'(step_reg);
    end
  end

endmodule

// File: tb/tb_dds_increment_bank.sv
// Bench for dds_increment_bank: directed scenarios with hand-derived values
// plus a randomized run against a plain-arithmetic reference model.
module tb_dds_increment_bank;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              sample_tick = 1'b0;
  logic [63:0]       out_port;
  logic              update_pulse;
  logic              ramping;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] m_shadow [NUM_CH];
  logic [31:0] m_target [NUM_CH];
  logic [31:0] m_active [NUM_CH];
  logic [31:0] m_step;
  logic        m_pending;
  logic        m_pulse;

  dds_increment_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .sample_tick  (sample_tick),
    .out_port     (out_port),
    .update_pulse (update_pulse),
    .ramping      (ramping)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_shadow[c] = '0;
      m_target[c] = '0;
      m_active[c] = '0;
    end
    m_step = '0;
    m_pending = 1'b0;
    m_pulse = 1'b0;
  endtask

  // One clock edge of the behavioural model, using the inputs the DUT saw
  task automatic model_edge(input logic [2:0] a, input logic w, input logic [31:0] d,
                            input logic t);
    logic apply, abort, commit;
    longint ac, ta, s;
    apply  = t && m_pending;
    abort  = w && (a == 3'd4) && d[1];
    commit = w && (a == 3'd4) && d[0];
    for (int c = 0; c < NUM_CH; c++) begin
      ac = longint'(m_active[c]);
      ta = longint'(m_target[c]);
      s  = longint'(m_step);
      if (abort) ac = ta;
      if (apply) begin
        m_target[c] = m_shadow[c];
        if (m_step == 0) ac = longint'(m_shadow[c]);
      end else if (t && !abort) begin
        if (ac < ta) ac = (ac + s >= ta) ? ta : ac + s;
        else if (ac > ta) ac = (ac - s <= ta) ? ta : ac - s;
      end
      m_active[c] = ac[31:0];
    end
    if (apply) m_pending = 1'b0;
    else if (commit) m_pending = 1'b1;
    if (w && a < 3'(NUM_CH)) m_shadow[a] = d;
    if (w && a == 3'd6) m_step = d;
    m_pulse = apply;
  endtask

  function automatic logic [63:0] m_out();
    return {m_active[1], m_active[0]};
  endfunction

  function automatic logic m_ramping();
    return (m_active[0] != m_target[0]) || (m_active[1] != m_target[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_shadow[0];
      3'd1: return m_shadow[1];
      3'd2: return m_active[0];
      3'd3: return m_active[1];
      3'd5: return {30'd0, m_ramping(), m_pending};
      3'd6: return m_step;
      default: return 32'd0;
    endcase
  endfunction

  // Drive one clock of bus/tick stimulus; called just after a rising edge
  task automatic bus_cycle(input logic [2:0] a, input logic w, input logic [31:0] d,
                           input logic t);
    address = a; chipselect = w; write_n = ~w; writedata = d; sample_tick = t;
    @(posedge clk);
    model_edge(a, w, d, t);
    #1;
    chipselect = 1'b0; write_n = 1'b1; sample_tick = 1'b0;
    if (w || t) $display("[%0t] txn addr=%0d wr=%0b data=%h tick=%0b -> out=%h", $time, a, w, d, t, out_port);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    bus_cycle(a, 1'b1, d, 1'b0);
  endtask

  task automatic tick();
    bus_cycle(3'd0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic idle();
    bus_cycle(3'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    v = readdata;
    chipselect = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    n_checks++; if (out_port !== 64'd0) $display("FAIL reset_out got=%h need=0", out_port); else n_pass++;
    n_checks++; if (ramping !== 1'b0) $display("FAIL reset_ramping got=%b need=0", ramping); else n_pass++;
    n_checks++; if (update_pulse !== 1'b0) $display("FAIL reset_pulse got=%b need=0", update_pulse); else n_pass++;
    rd(3'd5, v);
    n_checks++; if (v !== 32'd0) $display("FAIL reset_status got=%h need=0", v); else n_pass++;
    rd(3'd6, v);
    n_checks++; if (v !== 32'd0) $display("FAIL reset_step got=%h need=0", v); else n_pass++;
    rd(3'd0, v);
    n_checks++; if (v !== 32'd0) $display("FAIL reset_shadow0 got=%h need=0", v); else n_pass++;
  endtask

  task automatic test_jump();
    logic [31:0] v;
    wr_reg(3'd6, 32'd0);
    wr_reg(3'd0, 32'h1000);
    wr_reg(3'd1, 32'h2000);
    tick();
    n_checks++; if (out_port !== 64'd0) $display("FAIL jump_shadow_only got=%h need=0", out_port); else n_pass++;
    wr_reg(3'd4, 32'h1);
    idle();
    rd(3'd5, v);
    n_checks++; if (v !== 32'h1) $display("FAIL jump_pending got=%h need=1", v); else n_pass++;
    n_checks++; if (out_port !== 64'd0) $display("FAIL jump_before_tick got=%h need=0", out_port); else n_pass++;
    tick();
    n_checks++; if (out_port !== 64'h00002000_00001000) $display("FAIL jump_out got=%h need=0000200000001000", out_port); else n_pass++;
    n_checks++; if (update_pulse !== 1'b1) $display("FAIL jump_pulse_hi got=%b need=1", update_pulse); else n_pass++;
    idle();
    n_checks++; if (update_pulse !== 1'b0) $display("FAIL jump_pulse_lo got=%b need=0", update_pulse); else n_pass++;
    n_checks++; if (ramping !== 1'b0) $display("FAIL jump_ramping got=%b need=0", ramping); else n_pass++;
    rd(3'd2, v);
    n_checks++; if (v !== 32'h1000) $display("FAIL jump_active0 got=%h need=1000", v); else n_pass++;
  endtask

  task automatic test_slew();
    logic [31:0] up_seq [4];
    logic [31:0] dn_seq [4];
    up_seq = '{32'h100, 32'h200, 32'h300, 32'h350};
    dn_seq = '{32'h250, 32'h150, 32'h050, 32'h000};
    do_reset();
    wr_reg(3'd6, 32'h100);
    wr_reg(3'd0, 32'h350);
    wr_reg(3'd4, 32'h1);
    tick();
    n_checks++; if (out_port[31:0] !== 32'h0) $display("FAIL slew_commit_tick got=%h need=0", out_port[31:0]); else n_pass++;
    n_checks++; if (ramping !== 1'b1) $display("FAIL slew_ramping_start got=%b need=1", ramping); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      idle();
      tick();
      n_checks++; if (out_port !== {32'h0, up_seq[k]}) $display("FAIL slew_up_%0d got=%h need=%h", k, out_port, {32'h0, up_seq[k]}); else n_pass++;
    end
    n_checks++; if (ramping !== 1'b0) $display("FAIL slew_up_done got=%b need=0", ramping); else n_pass++;
    wr_reg(3'd0, 32'h0);
    wr_reg(3'd4, 32'h1);
    tick();
    n_checks++; if (out_port[31:0] !== 32'h350) $display("FAIL slew_dn_commit got=%h need=350", out_port[31:0]); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (out_port[31:0] !== dn_seq[k]) $display("FAIL slew_dn_%0d got=%h need=%h", k, out_port[31:0], dn_seq[k]); else n_pass++;
      if (k == 2) begin
        n_checks++; if (ramping !== 1'b1) $display("FAIL slew_dn_ramping got=%b need=1", ramping); else n_pass++;
      end
    end
    n_checks++; if (ramping !== 1'b0) $display("FAIL slew_dn_done got=%b need=0", ramping); else n_pass++;
  endtask

  task automatic test_races();
    logic [31:0] v;
    // state: step 0x100, everything at 0
    wr_reg(3'd0, 32'h500);
    wr_reg(3'd4, 32'h1);
    bus_cycle(3'd0, 1'b1, 32'h700, 1'b1);   // shadow write coincides with applying tick
    n_checks++; if (update_pulse !== 1'b1) $display("FAIL race_pulse got=%b need=1", update_pulse); else n_pass++;
    wr_reg(3'd4, 32'h2);                    // abort: active snaps onto committed target
    n_checks++; if (out_port[31:0] !== 32'h500) $display("FAIL race_old_shadow got=%h need=500", out_port[31:0]); else n_pass++;
    rd(3'd0, v);
    n_checks++; if (v !== 32'h700) $display("FAIL race_shadow_rd got=%h need=700", v); else n_pass++;
    bus_cycle(3'd4, 1'b1, 32'h1, 1'b1);     // commit written in a tick cycle
    n_checks++; if (update_pulse !== 1'b0) $display("FAIL race_commit_tick_pulse got=%b need=0", update_pulse); else n_pass++;
    n_checks++; if (ramping !== 1'b0) $display("FAIL race_commit_tick_ramp got=%b need=0", ramping); else n_pass++;
    tick();
    n_checks++; if (update_pulse !== 1'b1) $display("FAIL race_next_tick_pulse got=%b need=1", update_pulse); else n_pass++;
    tick();
    n_checks++; if (out_port[31:0] !== 32'h600) $display("FAIL race_slew got=%h need=600", out_port[31:0]); else n_pass++;
  endtask

  task automatic test_abort();
    do_reset();
    wr_reg(3'd6, 32'h100);
    wr_reg(3'd0, 32'h350);
    wr_reg(3'd4, 32'h1);
    tick(); tick(); tick();
    n_checks++; if (out_port[31:0] !== 32'h200) $display("FAIL abort_pre got=%h need=200", out_port[31:0]); else n_pass++;
    wr_reg(3'd4, 32'h2);
    n_checks++; if (out_port[31:0] !== 32'h350) $display("FAIL abort_snap got=%h need=350", out_port[31:0]); else n_pass++;
    n_checks++; if (ramping !== 1'b0) $display("FAIL abort_ramping got=%b need=0", ramping); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic        saw_pulse;
    wr_reg(3'd0, 32'h0);
    wr_reg(3'd4, 32'h1);
    tick(); tick();
    wr_reg(3'd0, 32'h10);
    wr_reg(3'd4, 32'h1);                    // leaves a commit pending mid-ramp
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_checks++; if (out_port !== 64'd0) $display("FAIL rstmid_out got=%h need=0", out_port); else n_pass++;
    n_checks++; if (ramping !== 1'b0) $display("FAIL rstmid_ramping got=%b need=0", ramping); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    saw_pulse = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (update_pulse) saw_pulse = 1'b1;
    end
    n_checks++; if (saw_pulse !== 1'b0) $display("FAIL rstmid_pulse got=%b need=0", saw_pulse); else n_pass++;
    n_checks++; if (out_port !== 64'd0) $display("FAIL rstmid_idle got=%h need=0", out_port); else n_pass++;
    rd(3'd5, v);
    n_checks++; if (v !== 32'd0) $display("FAIL rstmid_status got=%h need=0", v); else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0]  a, ra;
    logic        w, t;
    logic [31:0] d, v;
    for (int n = 0; n < 400; n++) begin
      w = ($urandom_range(0, 2) == 0);
      a = 3'($urandom_range(0, 7));
      case (a)
        3'd4:    d = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : 32'h1;
        3'd6:    d = 32'($urandom_range(0, 32'h400));
        default: d = 32'($urandom_range(0, 32'h2000));
      endcase
      t = ($urandom_range(0, 2) == 0);
      bus_cycle(a, w, d, t);
      n_checks++; if (out_port !== m_out()) $display("FAIL rnd_out[%0d] got=%h need=%h", n, out_port, m_out()); else n_pass++;
      n_checks++; if (update_pulse !== m_pulse) $display("FAIL rnd_pulse[%0d] got=%b need=%b", n, update_pulse, m_pulse); else n_pass++;
      n_checks++; if (ramping !== m_ramping()) $display("FAIL rnd_ramping[%0d] got=%b need=%b", n, ramping, m_ramping()); else n_pass++;
      ra = 3'($urandom_range(0, 7));
      rd(ra, v);
      n_checks++; if (v !== m_read(ra)) $display("FAIL rnd_read[%0d] addr=%0d got=%h need=%h", n, ra, v, m_read(ra)); else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_jump();
    test_slew();
    test_races();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
